// File: rtl/serial_bus_responder_if.sv
// Serial link and register-bus signals of serial_bus_responder.
// The responder is the slave side; the initiator/bus model is the master.
interface serial_bus_responder_if;
  logic        serialin;
  logic        serialout;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wrdata;
  logic [15:0] rddata;

  modport slave (
    input  serialin,
    input  rddata,
    output serialout,
    output wr,
    output addr,
    output wrdata
  );

  modport master (
    output serialin,
    output rddata,
    input  serialout,
    input  wr,
    input  addr,
    input  wrdata
  );
endinterface

// File: rtl/serial_bus_responder.sv
// Serial command responder: decodes 13-bit frames into register-bus reads/writes
// and returns status/data frames on a concurrent serial transmitter.
module serial_bus_responder #(
  parameter logic [7:0] RDSTAT  = 8'h02,
  parameter logic [7:0] WRSTAT  = 8'h01,
  parameter logic [7:0] BADSTAT = 8'hEE
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_bus_responder_if.slave  bus,
  output logic [15:0]            rdcount,
  output logic [15:0]            wrcount,
  output logic [15:0]            bytecount,
  output logic [15:0]            errcount,
  output logic                   txoverrun
);

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD, OP_BAD} op_t;

  function automatic logic [12:0] make_frame(input logic flag, input logic [7:0] d);
    return {2'b01, flag, d, 2'b00};
  endfunction

  logic        sin_q;
  rx_state_t   rx_state_q;
  logic [3:0]  bit_cnt_q;
  logic [8:0]  shift_q;
  logic        stop_err_q;
  logic [31:0] hold_q;
  op_t         op1_q, op2_q;
  logic [15:0] addr_q, wrdata_q;
  logic        wr_q;
  logic [38:0] tx_sh_q, pend_sh_q;
  logic [5:0]  tx_cnt_q, pend_cnt_q;
  logic        pend_v_q;
  logic        sout_q;
  logic [15:0] rdcount_q, wrcount_q, bytecount_q, errcount_q;
  logic        txoverrun_q;

  logic        rsp_v_d;
  logic [38:0] rsp_sh_d;
  logic [5:0]  rsp_cnt_d;
  logic        tx_last_d;

  // Response is built one cycle after the bus access so rddata reflects the new addr.
  always_comb begin
    rsp_v_d   = 1'b0;
    rsp_sh_d  = '0;
    rsp_cnt_d = '0;
    case (op2_q)
      OP_WR: begin
        rsp_v_d   = 1'b1;
        rsp_sh_d  = {make_frame(1'b1, WRSTAT), 26'd0};
        rsp_cnt_d = 6'd13;
      end
      OP_RD: begin
        rsp_v_d   = 1'b1;
        rsp_sh_d  = {make_frame(1'b0, bus.rddata[15:8]), make_frame(1'b0, bus.rddata[7:0]),
                     make_frame(1'b1, RDSTAT)};
        rsp_cnt_d = 6'd39;
      end
      OP_BAD: begin
        rsp_v_d   = 1'b1;
        rsp_sh_d  = {make_frame(1'b1, BADSTAT), 26'd0};
        rsp_cnt_d = 6'd13;
      end
      default: ;
    endcase
  end

  assign tx_last_d = (tx_cnt_q <= 6'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q       <= 1'b0;
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stop_err_q  <= 1'b0;
      hold_q      <= '0;
      op1_q       <= OP_NONE;
      op2_q       <= OP_NONE;
      addr_q      <= '0;
      wrdata_q    <= '0;
      wr_q        <= 1'b0;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      pend_sh_q   <= '0;
      pend_cnt_q  <= '0;
      pend_v_q    <= 1'b0;
      sout_q      <= 1'b0;
      rdcount_q   <= '0;
      wrcount_q   <= '0;
      bytecount_q <= '0;
      errcount_q  <= '0;
      txoverrun_q <= 1'b0;
    end else begin
      sin_q <= bus.serialin;
      wr_q  <= 1'b0;
      op1_q <= OP_NONE;
      op2_q <= op1_q;

      case (rx_state_q)
        RX_IDLE: begin
          if (sin_q) begin
            rx_state_q <= RX_BITS;
            bit_cnt_q  <= '0;
          end
        end
        RX_BITS: begin
          shift_q <= {shift_q[7:0], sin_q};
          if (bit_cnt_q == 4'd8) begin
            rx_state_q <= RX_STOP;
            bit_cnt_q  <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        RX_STOP: begin
          if (bit_cnt_q == 4'd0) begin
            stop_err_q <= sin_q;
            bit_cnt_q  <= 4'd1;
          end else begin
            rx_state_q <= RX_IDLE;
            if (stop_err_q || sin_q) begin
              errcount_q <= errcount_q + 16'd1;
            end else begin
              bytecount_q <= bytecount_q + 16'd1;
              if (!shift_q[8]) begin
                hold_q <= {hold_q[23:0], shift_q[7:0]};
              end else begin
                hold_q <= '0;
                case (shift_q[7:0])
                  8'h01: begin
                    addr_q   <= hold_q[15:0];
                    wrdata_q <= hold_q[31:16];
                    op1_q    <= OP_WR;
                  end
                  8'h02: begin
                    addr_q <= hold_q[15:0];
                    op1_q  <= OP_RD;
                  end
                  default: op1_q <= OP_BAD;
                endcase
              end
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase

      if (op1_q == OP_WR) begin
        wr_q      <= 1'b1;
        wrcount_q <= wrcount_q + 16'd1;
      end
      if (op1_q == OP_RD) rdcount_q <= rdcount_q + 16'd1;

      // On the final bit the next response (pending first) loads so frames stay back to back.
      sout_q  <= (tx_cnt_q != 6'd0) ? tx_sh_q[38] : 1'b0;
      tx_sh_q <= tx_sh_q << 1;
      if (tx_cnt_q != 6'd0) tx_cnt_q <= tx_cnt_q - 6'd1;
      if (tx_last_d) begin
        if (pend_v_q) begin
          tx_sh_q  <= pend_sh_q;
          tx_cnt_q <= pend_cnt_q;
          pend_v_q <= rsp_v_d;
          if (rsp_v_d) begin
            pend_sh_q  <= rsp_sh_d;
            pend_cnt_q <= rsp_cnt_d;
          end
        end else if (rsp_v_d) begin
          tx_sh_q  <= rsp_sh_d;
          tx_cnt_q <= rsp_cnt_d;
        end
      end else if (rsp_v_d) begin
        pend_sh_q  <= rsp_sh_d;
        pend_cnt_q <= rsp_cnt_d;
        pend_v_q   <= 1'b1;
        if (pend_v_q) txoverrun_q <= 1'b1;
      end
    end
  end

  assign bus.serialout = sout_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.wrdata    = wrdata_q;
  assign rdcount       = rdcount_q;
  assign wrcount       = wrcount_q;
  assign bytecount     = bytecount_q;
  assign errcount      = errcount_q;
  assign txoverrun     = txoverrun_q;

endmodule

// File: tb/tb_serial_bus_responder.sv
// Scoreboard bench for serial_bus_responder: stimulus pushes expected frames and
// bus writes; independent monitors decode serialout and wr and compare.
module tb_serial_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bus_responder_if bus();
  logic [15:0] rdcount, wrcount, bytecount, errcount;
  logic        txoverrun;

  serial_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rdcount   (rdcount),
    .wrcount   (wrcount),
    .bytecount (bytecount),
    .errcount  (errcount),
    .txoverrun (txoverrun)
  );

  // Register file model: addr 0001 reads BEEF, everything else addr^5A5A.
  always_comb bus.rddata = (bus.addr == 16'h0001) ? 16'hBEEF : (bus.addr ^ 16'h5A5A);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic flag; logic [7:0] d; int start;} frm_t;
  typedef struct {logic [15:0] a; logic [15:0] wd; int at;} wr_t;
  frm_t frm_q[$];
  wr_t  wr_q[$];
  logic rx_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_frame(input logic flag, input logic [7:0] d, input int start);
    frm_t e;
    e.flag = flag; e.d = d; e.start = start;
    frm_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] wd, input int at);
    wr_t e;
    e.a = a; e.wd = wd; e.at = at;
    wr_q.push_back(e);
  endtask

  // Drives one 13-bit frame; p is the cycle in which its first bit is driven.
  task automatic send_frame(input logic flag, input logic [7:0] d, input logic bad_stop,
                            output int p);
    logic [12:0] f;
    f = {2'b01, flag, d, 1'b0, bad_stop};
    p = 0;
    for (int k = 12; k >= 0; k--) begin
      @(posedge clk);
      #1;
      if (k == 12) p = cyc;
      bus.serialin = f[k];
    end
  endtask

  task automatic send_data(input logic [7:0] d);
    int p;
    send_frame(1'b0, d, 1'b0, p);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((frm_q.size() != 0 || wr_q.size() != 0 || rx_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      failures++;
      $display("FAIL %s drain_timeout actual frames_left=%0d wr_left=%0d required 0", name,
               frm_q.size(), wr_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  // Bus write monitor
  initial begin : wr_mon
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.wr === 1'b1) begin
        $display("wr addr=%h wrdata=%h cycle=%0d", bus.addr, bus.wrdata, cyc);
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual addr=%h wrdata=%h required no pulse", bus.addr,
                   bus.wrdata);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", {16'h0, bus.addr}, {16'h0, e.a});
          chk("wr_data", {16'h0, bus.wrdata}, {16'h0, e.wd});
          chk("wr_cycle", cyc, e.at);
        end
      end
    end
  end

  // serialout frame monitor: triggers on the 1 bit, then collects flag, data, stops.
  initial begin : rx_mon
    int          rx_n;
    int          rx_start;
    logic [10:0] rx_bits;
    frm_t        e;
    rx_n = 0; rx_start = 0; rx_bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (bus.serialout === 1'b1) begin
          rx_busy  = 1'b1;
          rx_n     = 0;
          rx_start = cyc;
        end
      end else begin
        rx_bits = {rx_bits[9:0], bus.serialout};
        rx_n++;
        if (rx_n == 11) begin
          rx_busy = 1'b0;
          $display("rx frame flag=%0b data=%h start=%0d", rx_bits[10], rx_bits[9:2], rx_start);
          if (frm_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_unexpected actual flag=%0b data=%h required none", rx_bits[10],
                     rx_bits[9:2]);
          end else begin
            e = frm_q.pop_front();
            chk("frame_flag", {31'h0, rx_bits[10]}, {31'h0, e.flag});
            chk("frame_data", {24'h0, rx_bits[9:2]}, {24'h0, e.d});
            chk("frame_stop", {30'h0, rx_bits[1:0]}, 32'h0);
            chk("frame_start", rx_start, e.start);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p, p0;
    bus.serialin = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_serialout", {31'h0, bus.serialout}, 32'h0);
    chk("rst_wr", {31'h0, bus.wr}, 32'h0);
    chk("rst_addr_wrdata", {bus.addr, bus.wrdata}, 32'h0);
    chk("rst_rd_wr_count", {rdcount, wrcount}, 32'h0);
    chk("rst_byte_err_count", {bytecount, errcount}, 32'h0);
    chk("rst_txoverrun", {31'h0, txoverrun}, 32'h0);

    // Write 1234 to 0003
    send_data(8'h12); send_data(8'h34); send_data(8'h00); send_data(8'h03);
    send_frame(1'b1, 8'h01, 1'b0, p);
    exp_wr(16'h0003, 16'h1234, p + 15);
    exp_frame(1'b1, 8'h01, p + 18);
    wait_drain("write");
    chk("write_wrcount", {16'h0, wrcount}, 32'd1);
    chk("write_bytecount", {16'h0, bytecount}, 32'd5);
    chk("write_rdcount", {16'h0, rdcount}, 32'd0);

    // Unknown command
    send_frame(1'b1, 8'h07, 1'b0, p);
    exp_frame(1'b1, 8'hEE, p + 18);
    wait_drain("unknown");
    chk("unknown_addr", {16'h0, bus.addr}, 32'h0003);
    chk("unknown_wrdata", {16'h0, bus.wrdata}, 32'h1234);
    chk("unknown_rd_wr_count", {rdcount, wrcount}, {16'd0, 16'd1});
    chk("unknown_bytecount", {16'h0, bytecount}, 32'd6);

    // Read from 0001
    send_data(8'h00); send_data(8'h01);
    send_frame(1'b1, 8'h02, 1'b0, p);
    exp_frame(1'b0, 8'hBE, p + 18);
    exp_frame(1'b0, 8'hEF, p + 31);
    exp_frame(1'b1, 8'h02, p + 44);
    wait_drain("read");
    chk("read_rdcount", {16'h0, rdcount}, 32'd1);
    chk("read_bytecount", {16'h0, bytecount}, 32'd9);
    chk("read_addr", {16'h0, bus.addr}, 32'h0001);

    // Framing error between valid bytes; write 5555 to 0004
    do_reset();
    send_data(8'h55);
    send_frame(1'b0, 8'hAA, 1'b1, p);
    send_data(8'h55); send_data(8'h00); send_data(8'h04);
    send_frame(1'b1, 8'h01, 1'b0, p);
    exp_wr(16'h0004, 16'h5555, p + 15);
    exp_frame(1'b1, 8'h01, p + 18);
    wait_drain("framing");
    chk("framing_errcount", {16'h0, errcount}, 32'd1);
    chk("framing_bytecount", {16'h0, bytecount}, 32'd5);
    chk("framing_wrcount", {16'h0, wrcount}, 32'd1);

    // Read followed immediately by two writes: second write overruns the pending slot
    do_reset();
    send_data(8'h00); send_data(8'h01);
    send_frame(1'b1, 8'h02, 1'b0, p0);
    exp_frame(1'b0, 8'hBE, p0 + 18);
    exp_frame(1'b0, 8'hEF, p0 + 31);
    exp_frame(1'b1, 8'h02, p0 + 44);
    exp_frame(1'b1, 8'h01, p0 + 57);
    exp_wr(16'h0000, 16'h0000, p0 + 13 + 15);
    exp_wr(16'h0000, 16'h0000, p0 + 26 + 15);
    send_frame(1'b1, 8'h01, 1'b0, p);
    send_frame(1'b1, 8'h01, 1'b0, p);
    wait_drain("b2b");
    chk("b2b_txoverrun", {31'h0, txoverrun}, 32'h1);
    chk("b2b_wrcount", {16'h0, wrcount}, 32'd2);
    chk("b2b_rdcount", {16'h0, rdcount}, 32'd1);

    // Reset asserted during the 6th bit of a write command frame
    send_data(8'h00); send_data(8'h05);
    begin : aborted_frame
      logic [12:0] f;
      f = {2'b01, 1'b1, 8'h01, 2'b00};
      for (int j = 0; j < 6; j++) begin
        @(posedge clk); #1;
        bus.serialin = f[12 - j];
        if (j == 5) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.serialin = 1'b0;
    end
    repeat (30) @(negedge clk);
    chk("midrst_rd_wr_count", {rdcount, wrcount}, 32'h0);
    chk("midrst_byte_err_count", {bytecount, errcount}, 32'h0);
    chk("midrst_txoverrun", {31'h0, txoverrun}, 32'h0);
    chk("midrst_serialout", {31'h0, bus.serialout}, 32'h0);
    chk("midrst_addr", {16'h0, bus.addr}, 32'h0);
    send_data(8'h00); send_data(8'h02);
    send_frame(1'b1, 8'h02, 1'b0, p);
    exp_frame(1'b0, 8'h5A, p + 18);
    exp_frame(1'b0, 8'h58, p + 31);
    exp_frame(1'b1, 8'h02, p + 44);
    wait_drain("midrst_read");
    chk("midrst_read_rdcount", {16'h0, rdcount}, 32'd1);
    chk("midrst_read_bytecount", {16'h0, bytecount}, 32'd3);
    chk("midrst_read_wrcount", {16'h0, wrcount}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
